// File: rtl/alu_64bit.sv
// alu_64bit: 64-bit NOR/XOR/ADD/SUB ALU built as a ripple chain of bit slices, one output register.
// Optional ALU64_FLAGS_EN adds registered zero and signed-overflow outputs.
module alu_64bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic [1:0]  op,
    output logic [63:0] s,
    output logic        cout
`ifdef ALU64_FLAGS_EN
    ,
    output logic        zero,
    output logic        ovf
`endif
);

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic        arith;
    logic        sub;
    logic [64:0] c;
    logic [63:0] bx;
    logic [63:0] s_d;
    logic        cout_d;
    logic [63:0] s_q;
    logic        cout_q;

    assign arith = op[1];
    assign sub   = (op == OP_SUB);

    // Each loop iteration is one 1-bit slice; carry is gated off for logic ops
    always_comb begin
        c      = '0;
        bx     = '0;
        s_d    = '0;
        c[0]   = arith & cin;
        for (int i = 0; i < 64; i++) begin
            bx[i]   = b[i] ^ sub;
            c[i+1]  = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
            unique case (op)
                OP_NOR: s_d[i] = ~(a[i] | b[i]);
                OP_XOR: s_d[i] = a[i] ^ b[i];
                OP_ADD,
                OP_SUB: s_d[i] = a[i] ^ bx[i] ^ c[i];
            endcase
        end
        cout_d = arith & c[64];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

`ifdef ALU64_FLAGS_EN
    logic zero_d;
    logic ovf_d;
    logic zero_q;
    logic ovf_q;

    assign zero_d = (s_d == 64'h0);
    assign ovf_d  = arith & (c[64] ^ c[63]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_64bit.sv
// tb_alu_64bit: randomized self-checking bench for alu_64bit against an arithmetic reference model.
// Flag outputs are checked when ALU64_FLAGS_EN is defined.
module tb_alu_64bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [1:0]  op;
    logic [63:0] s;
    logic        cout;
`ifdef ALU64_FLAGS_EN
    logic        zero;
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_64bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .op   (op),
        .s    (s),
        .cout (cout)
`ifdef ALU64_FLAGS_EN
        ,
        .zero (zero),
        .ovf  (ovf)
`endif
    );

    // Packed {ovf, zero, cout, s}; flag bits read as 0 when flags are not built
    function automatic logic [66:0] got();
`ifdef ALU64_FLAGS_EN
        return {ovf, zero, cout, s};
`else
        return {2'b00, cout, s};
`endif
    endfunction

    function automatic logic [66:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mc, input logic [1:0] mop);
        logic [64:0] sum;
        logic [63:0] bb;
        logic        ov;
        ov = 1'b0;
        bb = mb;
        case (mop)
            2'd0:    sum = {1'b0, ~(ma | mb)};
            2'd1:    sum = {1'b0, ma ^ mb};
            default: begin
                if (mop == 2'd3) bb = ~mb;
                sum = {1'b0, ma} + {1'b0, bb} + {64'd0, mc};
                ov  = (ma[63] == bb[63]) && (sum[63] != ma[63]);
            end
        endcase
`ifdef ALU64_FLAGS_EN
        return {ov, sum[63:0] == 64'd0, sum};
`else
        return {2'b00, sum};
`endif
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic [63:0] da, input logic [63:0] db,
                         input logic dc, input logic [1:0] dop);
        @(negedge clk);
        a   = da;
        b   = db;
        cin = dc;
        op  = dop;
    endtask

    task automatic test_reset();
        logic [66:0] exp;
        rst_n = 1'b1;
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 2'd1);
        exp = model(a, b, cin, op);
        @(posedge clk); #1;
        checks++;
        if (got() !== exp) begin
            errors++;
            $display("FAIL pre_reset got %h exp %h", got(), exp);
        end
        #2;
        a = rnd64(); b = rnd64(); op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
        rst_n = 1'b0;
        #1;
        checks++;
        if (got() !== 67'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", got());
        end
        @(posedge clk); #1;
        checks++;
        if (got() !== 67'd0) begin
            errors++;
            $display("FAIL reset_hold got %h exp 0", got());
        end
        drive(64'h1234, 64'h1, 1'b1, 2'd2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (got() !== 67'd0) begin
            errors++;
            $display("FAIL release_no_edge got %h exp 0", got());
        end
        exp = model(a, b, cin, op);
        @(posedge clk); #1;
        checks++;
        if (got() !== exp) begin
            errors++;
            $display("FAIL first_after_release got %h exp %h", got(), exp);
        end
        // Reset asserted while a result is pending must discard it
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 2'd0);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (got() !== 67'd0) begin
            errors++;
            $display("FAIL reset_discard got %h exp 0", got());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sub_zero();
        logic [63:0] es [3];
        logic        ec [3];
        logic        ci [3];
        ci[0] = 1'b0; es[0] = 64'hFFFF_FFFF_FFFF_FFFF; ec[0] = 1'b0;
        ci[1] = 1'b1; es[1] = 64'h0;                   ec[1] = 1'b1;
        ci[2] = 1'b0; es[2] = 64'hFFFF_FFFF_FFFF_FFFF; ec[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(64'h0, 64'h0, ci[k], 2'd3);
            @(posedge clk); #1;
            checks++;
            if (s !== es[k] || cout !== ec[k]) begin
                errors++;
                $display("FAIL sub_zero[%0d] got %h/%b exp %h/%b", k, s, cout, es[k], ec[k]);
            end
`ifdef ALU64_FLAGS_EN
            checks++;
            if (zero !== ec[k] || ovf !== 1'b0) begin
                errors++;
                $display("FAIL sub_zero_flags[%0d] got z%b o%b exp z%b o0", k, zero, ovf, ec[k]);
            end
`endif
        end
    endtask

    task automatic test_add_wrap();
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'd2);
        @(posedge clk); #1;
        checks++;
        if (s !== 64'h0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap got %h/%b exp 0/1", s, cout);
        end
`ifdef ALU64_FLAGS_EN
        checks++;
        if (zero !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap_flags got z%b o%b exp z1 o0", zero, ovf);
        end
`endif
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'd2);
        @(posedge clk); #1;
        checks++;
        if (s !== 64'h8000_0000_0000_0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL add_ovf got %h/%b exp 8000000000000000/0", s, cout);
        end
`ifdef ALU64_FLAGS_EN
        checks++;
        if (zero !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf_flags got z%b o%b exp z0 o1", zero, ovf);
        end
`endif
    endtask

    task automatic test_logic();
        drive(64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0000_0F0F_0000, 1'b1, 2'd0);
        @(posedge clk); #1;
        checks++;
        if (s !== 64'h0000_0F0F_0000_0F0F || cout !== 1'b0) begin
            errors++;
            $display("FAIL nor got %h/%b exp 00000f0f00000f0f/0", s, cout);
        end
        drive(64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd1);
        @(posedge clk); #1;
        checks++;
        if (s !== 64'h5555_5555_5555_5555 || cout !== 1'b0) begin
            errors++;
            $display("FAIL xor got %h/%b exp 5555555555555555/0", s, cout);
        end
    endtask

    task automatic test_back_to_back();
        logic [66:0] prev;
        logic [66:0] exp;
        prev = got();
        for (int n = 0; n < 10000; n++) begin
            drive(rnd64(), rnd64(), 1'($urandom), 2'($urandom_range(0, 3)));
            exp = model(a, b, cin, op);
            #1;
            checks++;
            if (got() !== prev) begin
                errors++;
                $display("FAIL b2b_hold[%0d] got %h exp %h", n, got(), prev);
            end
            @(posedge clk); #1;
            checks++;
            if (got() !== exp) begin
                errors++;
                $display("FAIL b2b[%0d] op %0d a %h b %h cin %b got %h exp %h",
                         n, op, a, b, cin, got(), exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        op    = 2'd0;
        test_reset();
        test_sub_zero();
        test_add_wrap();
        test_logic();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
